// File: rtl/sonic_eth_tx_status_pkg.sv
// Shared definitions for the 10G TX status collector: status field layout,
// record widths, the buffered record type and the statistics FSM states.
package sonic_eth_tx_status_pkg;

  localparam int unsigned STATUS_W  = 40;
  localparam int unsigned ERR_W     = 7;
  localparam int unsigned REC_W     = STATUS_W + ERR_W;

  localparam int unsigned LEN_LSB   = 0;
  localparam int unsigned LEN_MSB   = 15;
  localparam int unsigned LEN_W     = LEN_MSB - LEN_LSB + 1;
  localparam int unsigned PAUSE_BIT = 16;
  localparam int unsigned VLAN_BIT  = 17;
  localparam int unsigned SVLAN_BIT = 18;
  localparam int unsigned BCAST_BIT = 19;
  localparam int unsigned MCAST_BIT = 20;

  localparam int unsigned HIST_W    = 16;

  // Raw status record as buffered in the FIFO: {error, data}
  typedef struct packed {
    logic [ERR_W-1:0]    error;
    logic [STATUS_W-1:0] data;
  } status_rec_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_UPDATE = 1'b1
  } stat_state_e;

  // Frame byte count field of a status word
  function automatic logic [LEN_W-1:0] rec_len(input logic [STATUS_W-1:0] d);
    return d[LEN_MSB:LEN_LSB];
  endfunction

endpackage

// File: rtl/sonic_eth_tx_status_fifo.sv
// Single-clock status record FIFO. Pops on an empty FIFO are ignored (no
// fall-through); a push into a full FIFO only succeeds alongside a pop.
module sonic_eth_tx_status_fifo
  import sonic_eth_tx_status_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  status_rec_t                push_rec,
  input  logic                       pop,
  output logic                       rd_valid,
  output status_rec_t                rd_rec,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0] wr_cnt_q, wr_cnt_d;
  logic [PW-1:0] rd_cnt_q, rd_cnt_d;
  logic [PW-1:0] level_q, level_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          rd_valid_q, rd_valid_d;
  status_rec_t   rd_rec_q, rd_rec_d;
  logic          push_ok, pop_ok;
  status_rec_t   mem_q [DEPTH];

  // Pointer, occupancy and read-port next state
  always_comb begin
    pop_ok     = pop && !empty_q;
    push_ok    = push && (!full_q || pop_ok);
    wr_cnt_d   = wr_cnt_q + PW'(push_ok);
    rd_cnt_d   = rd_cnt_q + PW'(pop_ok);
    level_d    = wr_cnt_d - rd_cnt_d;
    full_d     = (level_d == PW'(DEPTH));
    empty_d    = (level_d == '0);
    rd_valid_d = pop_ok;
    rd_rec_d   = pop_ok ? mem_q[rd_cnt_q[AW-1:0]] : rd_rec_q;
  end

  // Control registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      level_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      rd_valid_q <= 1'b0;
      rd_rec_q   <= '0;
    end else begin
      wr_cnt_q   <= wr_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      level_q    <= level_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      rd_valid_q <= rd_valid_d;
      rd_rec_q   <= rd_rec_d;
    end
  end

  // Storage array; contents are meaningless until written
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_cnt_q[AW-1:0]] <= push_rec;
  end

  assign rd_valid = rd_valid_q;
  assign rd_rec   = rd_rec_q;
  assign level    = level_q;
  assign full     = full_q;
  assign empty    = empty_q;

endmodule

// File: rtl/sonic_eth_10g_tx_status_collector.sv
// 10G TX status collector: saturating frame/octet statistics plus a FIFO of
// raw status records. Define SONIC_TX_STATUS_ERR_HIST_EN to add a per-error-bit
// histogram output (err_hist).
module sonic_eth_10g_tx_status_collector
  import sonic_eth_tx_status_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned FRM_CNT_W  = 32,
  parameter int unsigned OCT_CNT_W  = 48
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          in_valid,
  input  logic [39:0]                   in_data,
  input  logic [6:0]                    in_error,
  input  logic                          clr,
  input  logic                          rd_req,
  output logic                          rd_valid,
  output logic [46:0]                   rd_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [FRM_CNT_W-1:0]          frames_ok,
  output logic [FRM_CNT_W-1:0]          frames_err,
  output logic [OCT_CNT_W-1:0]          octets_ok,
  output logic [FRM_CNT_W-1:0]          fifo_ovf
`ifdef SONIC_TX_STATUS_ERR_HIST_EN
  ,
  output logic [111:0]                  err_hist
`endif
);

  localparam int unsigned OSUM_W = OCT_CNT_W + 1;

  stat_state_e          state_q, state_d;
  status_rec_t          rec1_q, rec1_d;
  logic                 clr1_q, clr1_d;
  logic [FRM_CNT_W-1:0] frames_ok_q, frames_ok_d;
  logic [FRM_CNT_W-1:0] frames_err_q, frames_err_d;
  logic [OCT_CNT_W-1:0] octets_ok_q, octets_ok_d;
  logic [FRM_CNT_W-1:0] fifo_ovf_q, fifo_ovf_d;
  logic [OSUM_W-1:0]    oct_sum;
  logic                 upd, good, drop_c;
  logic                 fifo_full, fifo_empty;
  status_rec_t          fifo_rd_rec;

  // Next-state and counter update; clr travels with the beat it arrived with
  always_comb begin
    state_d      = in_valid ? ST_UPDATE : ST_IDLE;
    rec1_d       = '{error: in_error, data: in_data};
    clr1_d       = clr;
    frames_ok_d  = clr1_q ? '0 : frames_ok_q;
    frames_err_d = clr1_q ? '0 : frames_err_q;
    octets_ok_d  = clr1_q ? '0 : octets_ok_q;
    fifo_ovf_d   = clr1_q ? '0 : fifo_ovf_q;
    oct_sum      = '0;
    upd          = (state_q == ST_UPDATE);
    good         = (rec1_q.error == '0);
    drop_c       = upd && fifo_full && !(rd_req && !fifo_empty);
    if (upd) begin
      if (good) begin
        if (frames_ok_d != '1) frames_ok_d = frames_ok_d + FRM_CNT_W'(1);
        oct_sum     = {1'b0, octets_ok_d} + OSUM_W'(rec_len(rec1_q.data));
        octets_ok_d = oct_sum[OCT_CNT_W] ? '1 : oct_sum[OCT_CNT_W-1:0];
      end else begin
        if (frames_err_d != '1) frames_err_d = frames_err_d + FRM_CNT_W'(1);
      end
    end
    if (drop_c && (fifo_ovf_d != '1)) fifo_ovf_d = fifo_ovf_d + FRM_CNT_W'(1);
  end

  // Input register stage and FSM state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      rec1_q  <= '0;
      clr1_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rec1_q  <= rec1_d;
      clr1_q  <= clr1_d;
    end
  end

  // Statistics counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frames_ok_q  <= '0;
      frames_err_q <= '0;
      octets_ok_q  <= '0;
      fifo_ovf_q   <= '0;
    end else begin
      frames_ok_q  <= frames_ok_d;
      frames_err_q <= frames_err_d;
      octets_ok_q  <= octets_ok_d;
      fifo_ovf_q   <= fifo_ovf_d;
    end
  end

  sonic_eth_tx_status_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (upd),
    .push_rec (rec1_q),
    .pop      (rd_req),
    .rd_valid (rd_valid),
    .rd_rec   (fifo_rd_rec),
    .level    (fifo_level),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign rd_data    = fifo_rd_rec;
  assign frames_ok  = frames_ok_q;
  assign frames_err = frames_err_q;
  assign octets_ok  = octets_ok_q;
  assign fifo_ovf   = fifo_ovf_q;

`ifdef SONIC_TX_STATUS_ERR_HIST_EN
  logic [HIST_W-1:0] hist_q [ERR_W];
  logic [HIST_W-1:0] hist_d [ERR_W];

  // Per-error-bit saturating histogram, same clear priority as the counters
  always_comb begin
    for (int i = 0; i < int'(ERR_W); i++) begin
      hist_d[i] = clr1_q ? '0 : hist_q[i];
      if (upd && rec1_q.error[i] && (hist_d[i] != '1))
        hist_d[i] = hist_d[i] + HIST_W'(1);
    end
  end

  // Histogram registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(ERR_W); i++) hist_q[i] <= '0;
    end else begin
      for (int i = 0; i < int'(ERR_W); i++) hist_q[i] <= hist_d[i];
    end
  end

  // Flatten histogram onto the output bus
  always_comb begin
    err_hist = '0;
    for (int i = 0; i < int'(ERR_W); i++) err_hist[i*HIST_W +: HIST_W] = hist_q[i];
  end
`endif

endmodule
